// File: rtl/spi_miso_serializer.sv
// MISO transmit path for the SPI slave. A one-entry hold buffer feeds an MSB-first
// shift register that drives one bit per clock during the read-data phase.
module spi_miso_serializer #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              miso,
    output logic              miso_oe,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              buf_full,
    output logic              tx_udr,
    output logic              tx_ovr
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StShift = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              full_q, full_d;
    logic              miso_q, miso_d;
    logic              done_q, done_d;
    logic              udr_q, udr_d;
    logic              ovr_q, ovr_d;

    logic              start_ok;
    logic              drain;
    logic              bypass;
    logic [DATA_W-1:0] word;

    // A start is also accepted on the edge that retires the last bit, so words run gap-free.
    assign start_ok = !ss_n && tx_start &&
                      ((state_q == StIdle) || (cnt_q == LAST));
    assign drain    = start_ok && full_q;
    assign bypass   = start_ok && !full_q && tx_valid;
    assign word     = full_q ? buf_q : (tx_valid ? tx_data : '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        miso_d  = 1'b0;
        buf_d   = buf_q;
        full_d  = full_q;

        if (ss_n) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (start_ok) begin
            state_d = StShift;
            cnt_d   = '0;
            miso_d  = word[DATA_W-1];
            sh_d    = word << 1;
        end else if (state_q == StShift) begin
            if (cnt_q == LAST) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                miso_d = sh_q[DATA_W-1];
                sh_d   = sh_q << 1;
            end
        end

        done_d = (state_d == StShift) && (cnt_d == LAST);
        udr_d  = start_ok && !full_q && !tx_valid;
        ovr_d  = tx_valid && full_q && !drain;

        // A bypassed word goes straight to the shifter and never occupies the buffer.
        if (tx_valid && !bypass) begin
            buf_d  = tx_data;
            full_d = 1'b1;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sh_q    <= '0;
            buf_q   <= '0;
            full_q  <= 1'b0;
            miso_q  <= 1'b0;
            done_q  <= 1'b0;
            udr_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            miso_q  <= miso_d;
            done_q  <= done_d;
            udr_q   <= udr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = (state_q == StShift);
    assign tx_busy  = (state_q == StShift);
    assign tx_done  = done_q;
    assign buf_full = full_q;
    assign tx_udr   = udr_q;
    assign tx_ovr   = ovr_q;

endmodule

// File: tb/tb_spi_miso_serializer.sv
// Self-checking bench for spi_miso_serializer: directed scenarios plus random traffic,
// checked every cycle against a transfer-level model.
module tb_spi_miso_serializer;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ss_n = 1'b1;
    logic          tx_start = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          miso, miso_oe, tx_busy, tx_done, buf_full, tx_udr, tx_ovr;

    int n_checks = 0;
    int n_fail   = 0;

    spi_miso_serializer #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ss_n     (ss_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .buf_full (buf_full),
        .tx_udr   (tx_udr),
        .tx_ovr   (tx_ovr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pos is the index of the bit on miso (-1 when not transferring).
    int          m_pos = -1;
    logic [DW-1:0] m_word = '0;
    logic [DW-1:0] m_buf = '0;
    logic        m_full = 1'b0;
    logic        m_udr = 1'b0, m_ovr = 1'b0;
    bit          m_valid = 1'b0;

    // Observations of the DUT used by the directed checks.
    logic [DW-1:0] cap = '0;
    logic [DW-1:0] last_word = '0;
    int          done_cnt = 0, udr_cnt = 0, ovr_cnt = 0;

    always @(posedge clk) begin
        logic can_start, drain, byp;
        if (rst) begin
            m_pos = -1; m_full = 1'b0; m_buf = '0; m_udr = 1'b0; m_ovr = 1'b0;
            m_valid = 1'b1;
        end else begin
            can_start = !ss_n && tx_start && (m_pos == -1 || m_pos == DW - 1);
            drain = can_start && m_full;
            byp   = can_start && !m_full && tx_valid;
            m_udr = can_start && !m_full && !tx_valid;
            m_ovr = tx_valid && m_full && !drain;
            if (ss_n) m_pos = -1;
            else if (can_start) begin
                m_word = m_full ? m_buf : (tx_valid ? tx_data : '0);
                m_pos = 0;
            end else if (m_pos >= 0) m_pos = (m_pos == DW - 1) ? -1 : m_pos + 1;
            if (tx_valid && !byp) begin
                m_buf = tx_data; m_full = 1'b1;
            end else if (drain) m_full = 1'b0;
        end
        #1;
        if (m_valid) begin
            check("miso",     miso,     (m_pos >= 0) ? m_word[DW-1-m_pos] : 1'b0);
            check("miso_oe",  miso_oe,  m_pos >= 0);
            check("tx_busy",  tx_busy,  m_pos >= 0);
            check("tx_done",  tx_done,  m_pos == DW - 1);
            check("buf_full", buf_full, m_full);
            check("tx_udr",   tx_udr,   m_udr);
            check("tx_ovr",   tx_ovr,   m_ovr);
        end
        if (miso_oe) cap = {cap[DW-2:0], miso};
        if (tx_done) begin last_word = cap; done_cnt++; end
        if (tx_udr) udr_cnt++;
        if (tx_ovr) ovr_cnt++;
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [DW-1:0] d);
        tx_data = d; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic start();
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Returns on the negedge where tx_done is visible.
    task automatic wait_done(input string name);
        int prev = done_cnt;
        int k = 0;
        while (done_cnt == prev && k < 30) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done_seen"}, done_cnt != prev, 1'b1);
    endtask

    initial begin
        int d0, u0, o0;
        idle_cycles(3);
        rst = 1'b0;
        ss_n = 1'b0;
        check("rst_oe", miso_oe, 1'b0);
        check("rst_full", buf_full, 1'b0);

        // Buffered 0xA5.
        load(8'hA5);
        check("a5_full", buf_full, 1'b1);
        start();
        check("a5_drained", buf_full, 1'b0);
        check("a5_first_bit", miso, 1'b1);
        wait_done("a5");
        check("a5_word", last_word, 8'hA5);
        idle_cycles(2);

        // Underrun shifts zeros.
        u0 = udr_cnt;
        cap = '1;
        start();
        check("udr_pulse", tx_udr, 1'b1);
        wait_done("udr");
        check("udr_word", last_word, 8'h00);
        check("udr_count", udr_cnt - u0, 1);
        idle_cycles(2);

        // Bypass.
        u0 = udr_cnt;
        tx_data = 8'h3C; tx_valid = 1'b1; tx_start = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0; tx_start = 1'b0;
        check("byp_full", buf_full, 1'b0);
        wait_done("byp");
        check("byp_word", last_word, 8'h3C);
        check("byp_no_udr", udr_cnt - u0, 0);
        idle_cycles(2);

        // Overwrite, reload during shift, back-to-back start.
        o0 = ovr_cnt;
        load(8'h11);
        load(8'h22);
        check("ovr_pulse", tx_ovr, 1'b1);
        start();
        idle_cycles(2);
        load(8'h33);
        check("reload_full", buf_full, 1'b1);
        wait_done("ovr");
        check("ovr_word", last_word, 8'h22);
        start();
        check("b2b_no_gap", miso_oe, 1'b1);
        wait_done("b2b");
        check("b2b_word", last_word, 8'h33);
        check("ovr_count", ovr_cnt - o0, 1);
        idle_cycles(2);

        // Abort after three bits; buffered 0x5A survives.
        d0 = done_cnt;
        load(8'hF0);
        start();
        load(8'h5A);
        idle_cycles(1);
        ss_n = 1'b1;
        @(negedge clk);
        check("abort_oe", miso_oe, 1'b0);
        check("abort_full", buf_full, 1'b1);
        idle_cycles(DW);
        ss_n = 1'b0;
        check("abort_no_done", done_cnt - d0, 0);
        start();
        wait_done("after_abort");
        check("after_abort_word", last_word, 8'h5A);
        idle_cycles(2);

        // Reset mid-shift with a full buffer.
        load(8'h77);
        start();
        load(8'h88);
        idle_cycles(2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_oe", miso_oe, 1'b0);
        check("rst_mid_full", buf_full, 1'b0);
        check("rst_mid_miso", miso, 1'b0);
        start();
        check("rst_mid_udr", tx_udr, 1'b1);
        idle_cycles(DW + 2);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            ss_n     = ($urandom_range(0, 39) == 0);
            tx_start = ($urandom_range(0, 5) == 0);
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = DW'($urandom);
            rst      = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rst = 1'b0; tx_start = 1'b0; tx_valid = 1'b0; ss_n = 1'b1;
        idle_cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
